// File: rtl/distance_filter.sv
// Sliding-window mean filter for ultrasonic range samples, with stability and timeout flags.
// Optional outlier rejection is compiled in by defining DISTANCE_FILTER_OUTLIER_EN.
module distance_filter #(
  parameter int unsigned DEPTH_LOG2     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned STABLE_TOL     = 2,
  parameter int unsigned OUTLIER_TOL    = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] distance_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [31:0] distance_o,
  output logic        stable_o,
  output logic        timeout_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned SumW  = 32 + DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam logic [31:0] TmoMax    = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] StableTol = 32'(STABLE_TOL);

  typedef enum logic {StFill, StRun} state_e;

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_e            state_q, state_d;
  logic [SumW-1:0]   sum_q, sum_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       tmo_cnt_q, tmo_cnt_d;
  logic              valid_q, valid_d;
  logic [31:0]       dist_q, dist_d;
  logic              stable_q, stable_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       win_q [Depth];

  logic [SumW-1:0]   new_ext;
  logic [SumW-1:0]   evict_ext;
  logic [SumW-1:0]   sum_upd;
  logic [31:0]       new_mean;
  logic              new_close;
  logic [31:0]       tmo_inc;
  logic              tmo_hit;
  logic              win_clr;
  logic              accept;
  logic              take;

  assign new_ext   = {{DEPTH_LOG2{1'b0}}, distance_i};
  // Once the window is full, wr_ptr points at the oldest entry, which is the one evicted.
  assign evict_ext = (state_q == StRun) ? {{DEPTH_LOG2{1'b0}}, win_q[wr_ptr_q]} : '0;
  assign sum_upd   = sum_q + new_ext - evict_ext;
  assign new_mean  = sum_upd[SumW-1:DEPTH_LOG2];
  assign new_close = abs_diff(new_mean, dist_q) <= StableTol;

  assign tmo_inc = tmo_cnt_q + 32'd1;
  assign tmo_hit = !flush_i && !valid_i && (tmo_cnt_q != TmoMax) && (tmo_inc == TmoMax);
  assign win_clr = flush_i || tmo_hit;

`ifdef DISTANCE_FILTER_OUTLIER_EN
  localparam logic [31:0] OutlierTol = 32'(OUTLIER_TOL);

  logic [1:0] rej_q, rej_d;
  logic       outlier;

  assign outlier = (state_q == StRun) && (abs_diff(distance_i, dist_q) > OutlierTol);
  // A third consecutive outlier is taken as a genuine step change and accepted.
  assign accept  = !outlier || (rej_q == 2'd2);

  always_comb begin
    rej_d = rej_q;
    if (win_clr || take) begin
      rej_d = 2'd0;
    end else if (valid_i) begin
      rej_d = rej_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_q <= 2'd0;
    end else begin
      rej_q <= rej_d;
    end
  end
`else
  localparam int unsigned UnusedOutlierTol = OUTLIER_TOL;

  assign accept = 1'b1;
`endif

  assign take = valid_i && !flush_i && accept;

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    valid_d   = 1'b0;
    dist_d    = dist_q;
    stable_d  = stable_q;
    timeout_d = timeout_q;

    if (win_clr) begin
      state_d   = StFill;
      sum_d     = '0;
      count_d   = '0;
      wr_ptr_d  = '0;
      stable_d  = 1'b0;
      tmo_cnt_d = flush_i ? 32'd0 : tmo_inc;
      if (tmo_hit) begin
        timeout_d = 1'b1;
      end
    end else if (valid_i) begin
      tmo_cnt_d = 32'd0;
      timeout_d = 1'b0;
      if (take) begin
        sum_d    = sum_upd;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (state_q == StFill) begin
          count_d = count_q + CntW'(1);
          if (count_q == CntW'(Depth - 1)) begin
            state_d  = StRun;
            valid_d  = 1'b1;
            dist_d   = new_mean;
            stable_d = 1'b0;
          end
        end else begin
          valid_d  = 1'b1;
          dist_d   = new_mean;
          stable_d = new_close;
        end
      end
    end else if (tmo_cnt_q != TmoMax) begin
      tmo_cnt_d = tmo_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      sum_q     <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      tmo_cnt_q <= 32'd0;
      valid_q   <= 1'b0;
      dist_q    <= 32'd0;
      stable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      valid_q   <= valid_d;
      dist_q    <= dist_d;
      stable_q  <= stable_d;
      timeout_q <= timeout_d;
    end
  end

  // Window storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (take) begin
      win_q[wr_ptr_q] <= distance_i;
    end
  end

  assign valid_o    = valid_q;
  assign distance_o = dist_q;
  assign stable_o   = stable_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_distance_filter.sv
// Bench for distance_filter: directed vector table, corner sequences and random traffic
// checked against a queue-based window model.
module tb_distance_filter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 100;
  localparam int unsigned STOL  = 2;
  localparam int unsigned OTOL  = 50;
`ifdef DISTANCE_FILTER_OUTLIER_EN
  localparam bit OutlierEn = 1'b1;
`else
  localparam bit OutlierEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] distance_i;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] distance_o;
  logic        stable_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  distance_filter #(
    .DEPTH_LOG2    (2),
    .TIMEOUT_CYCLES(TMO),
    .STABLE_TOL    (STOL),
    .OUTLIER_TOL   (OTOL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .distance_i(distance_i),
    .flush_i   (flush_i),
    .valid_o   (valid_o),
    .distance_o(distance_o),
    .stable_o  (stable_o),
    .timeout_o (timeout_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the window is simply the list of the last accepted samples.
  logic [31:0] win[$];
  logic [31:0] m_dist;
  bit          m_valid, m_stable, m_timeout;
  int unsigned m_idle, m_rej;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          f;
    bit          ev;
    logic [31:0] ed;
    bit          es;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [31:0] adiff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    win.delete();
    m_dist = 0; m_valid = 0; m_stable = 0; m_timeout = 0; m_idle = 0; m_rej = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input bit f);
    bit          was_full, acc;
    longint unsigned s;
    logic [31:0] mean;
    m_valid = 0;
    if (f) begin
      win.delete(); m_stable = 0; m_idle = 0; m_rej = 0;
    end else if (v) begin
      m_idle = 0; m_timeout = 0;
      was_full = (win.size() == DEPTH);
      acc = 1;
      if (OutlierEn && was_full && adiff(d, m_dist) > OTOL && m_rej < 2) begin
        acc = 0; m_rej++;
      end
      if (acc) begin
        m_rej = 0;
        win.push_back(d);
        if (win.size() > DEPTH) void'(win.pop_front());
        if (win.size() == DEPTH) begin
          s = 0;
          foreach (win[i]) s += longint'(win[i]);
          mean     = 32'(s / DEPTH);
          m_valid  = 1;
          m_stable = was_full && (adiff(mean, m_dist) <= STOL);
          m_dist   = mean;
        end
      end
    end else if (m_idle < TMO) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_timeout = 1; win.delete(); m_stable = 0; m_rej = 0;
      end
    end
  endtask

  task automatic apply(input bit v, input logic [31:0] d, input bit f);
    valid_i = v; distance_i = d; flush_i = f;
    @(posedge clk); #1;
    model_step(v, d, f);
    chk("valid_o", valid_o, m_valid);
    chk("distance_o", distance_o, m_dist);
    chk("stable_o", stable_o, m_stable);
    chk("timeout_o", timeout_o, m_timeout);
    valid_i = 0; flush_i = 0;
  endtask

  initial begin
    bit          rv, rf;
    logic [31:0] rd;

    tbl[0]  = '{1'b1, 32'd100, 1'b0, 1'b0, 32'd0,   1'b0};
    tbl[1]  = '{1'b1, 32'd104, 1'b0, 1'b0, 32'd0,   1'b0};
    tbl[2]  = '{1'b1, 32'd108, 1'b0, 1'b0, 32'd0,   1'b0};
    tbl[3]  = '{1'b1, 32'd112, 1'b0, 1'b1, 32'd106, 1'b0};
    tbl[4]  = '{1'b1, 32'd116, 1'b0, 1'b1, 32'd110, 1'b0};
    tbl[5]  = '{1'b1, 32'd200, 1'b0, 1'b1, 32'd134, 1'b0};
    tbl[6]  = '{1'b1, 32'd200, 1'b0, 1'b1, 32'd157, 1'b0};
    tbl[7]  = '{1'b1, 32'd200, 1'b0, 1'b1, 32'd179, 1'b0};
    tbl[8]  = '{1'b1, 32'd200, 1'b0, 1'b1, 32'd200, 1'b0};
    tbl[9]  = '{1'b1, 32'd200, 1'b0, 1'b1, 32'd200, 1'b1};
    tbl[10] = '{1'b1, 32'd200, 1'b0, 1'b1, 32'd200, 1'b1};
    tbl[11] = '{1'b1, 32'd200, 1'b0, 1'b1, 32'd200, 1'b1};
    tbl[12] = '{1'b1, 32'd200, 1'b0, 1'b1, 32'd200, 1'b1};

    rst_n = 0; valid_i = 0; distance_i = 0; flush_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid_o", valid_o, 0);
    chk("reset distance_o", distance_o, 0);
    chk("reset stable_o", stable_o, 0);
    chk("reset timeout_o", timeout_o, 0);
    rst_n = 1;

    // Fill, mean, slide and stability
    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].f);
      chk($sformatf("tbl[%0d] valid", i), valid_o, tbl[i].ev);
      chk($sformatf("tbl[%0d] dist", i), distance_o, tbl[i].ed);
      chk($sformatf("tbl[%0d] stable", i), stable_o, tbl[i].es);
    end

    // Flush colliding with a sample: sample dropped, window empty
    apply(1, 32'd500, 1);
    chk("flush valid", valid_o, 0);
    chk("flush dist hold", distance_o, 200);
    chk("flush stable", stable_o, 0);
    for (int i = 0; i < 4; i++) begin
      apply(1, 32'd300, 0);
      chk($sformatf("post-flush valid %0d", i), valid_o, (i == 3));
    end
    chk("post-flush dist", distance_o, 300);

    // Outlier handling
    apply(0, 0, 1);
    for (int i = 0; i < 4; i++) apply(1, 32'd100, 0);
    chk("outlier base dist", distance_o, 100);
    apply(1, 32'd300, 0);
    if (OutlierEn) begin
      chk("outlier 1 rejected", valid_o, 0);
      apply(1, 32'd300, 0);
      chk("outlier 2 rejected", valid_o, 0);
      apply(1, 32'd300, 0);
    end
    chk("outlier accepted valid", valid_o, 1);
    chk("outlier accepted dist", distance_o, 150);

    // Timeout after TMO idle cycles, then refill
    for (int i = 0; i < TMO - 1; i++) apply(0, 0, 0);
    chk("timeout not yet", timeout_o, 0);
    apply(0, 0, 0);
    chk("timeout set", timeout_o, 1);
    chk("timeout stable", stable_o, 0);
    for (int i = 0; i < 4; i++) begin
      apply(1, 32'd50, 0);
      chk($sformatf("timeout refill valid %0d", i), valid_o, (i == 3));
      chk($sformatf("timeout cleared %0d", i), timeout_o, 0);
    end
    chk("timeout refill dist", distance_o, 50);

    // Reset mid-RUN
    apply(1, 32'd70, 0);
    rst_n = 0;
    #1;
    chk("midreset valid", valid_o, 0);
    chk("midreset dist", distance_o, 0);
    chk("midreset stable", stable_o, 0);
    chk("midreset timeout", timeout_o, 0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, 32'd80 + 32'(i), 0);
      chk($sformatf("post-reset valid %0d", i), valid_o, (i == 3));
    end
    chk("post-reset dist", distance_o, 81);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int k = 0; k < TMO + 3; k++) apply(0, 0, 0);
      end
      rv = ($urandom_range(0, 1) == 1);
      rf = ($urandom_range(0, 29) == 0);
      rd = ($urandom_range(0, 15) == 0) ? $urandom() : 32'd940 + 32'($urandom_range(0, 120));
      apply(rv, rd, rf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
DISTANCE_FILTER -- requirements
Module: distance_filter

Interface
REQ-001 Parameter DEPTH_LOG2, default 2, sets window depth DEPTH = 2^DEPTH_LOG2 samples (legal 1..4).
REQ-002 Parameter TIMEOUT_CYCLES, default 5000000, is the clk cycles without a sample before timeout (100 ms at 50 MHz).
REQ-003 Parameter STABLE_TOL, default 2, is the maximum |difference| between consecutive outputs still counted as stable.
REQ-004 Parameter OUTLIER_TOL, default 50, is the maximum |sample - current average| accepted when outlier rejection is compiled in.
REQ-005 clk  input  1  system clock (CLOCK_50 domain).
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 valid_i  input  1  one-cycle strobe from the ultrasonic ranger: distance_i is valid.
REQ-008 distance_i  input  32  raw distance sample, unsigned.
REQ-009 flush_i  input  1  synchronous window clear (controller start/back).
REQ-010 valid_o  output  1  one-cycle strobe: distance_o/stable_o updated.
REQ-011 distance_o  output  32  filtered distance (window mean), unsigned.
REQ-012 stable_o  output  1  last two outputs within STABLE_TOL.
REQ-013 timeout_o  output  1  no sample for TIMEOUT_CYCLES; window invalid.

Function
REQ-014 The block SHALL have states FILL and RUN; FILL holds fewer than DEPTH accepted samples, RUN a full window.
REQ-015 Accepted samples SHALL be written to a DEPTH-entry circular buffer at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
REQ-016 The running sum SHALL be 32+DEPTH_LOG2 bits and SHALL update as sum + new - evicted (evicted = 0 in FILL); no overflow is possible.
REQ-017 distance_o SHALL be sum >> DEPTH_LOG2 (truncating), registered.
REQ-018 In FILL, accepted samples SHALL NOT assert valid_o, except the sample completing the window: FILL -> RUN and valid_o asserts the next cycle.
REQ-019 In RUN, every accepted sample SHALL assert valid_o exactly one cycle after its valid_i; the latency is fixed at 1.
REQ-020 On each valid_o, stable_o SHALL become 1 iff |new distance_o - previous distance_o| <= STABLE_TOL; the first output after FILL SHALL set stable_o = 0.
REQ-021 A cycle counter SHALL clear on every valid_i and saturate; reaching TIMEOUT_CYCLES SHALL set timeout_o = 1, clear the window (sum, count, wr_ptr = 0), set stable_o = 0 and enter FILL.
REQ-022 timeout_o SHALL clear on the next valid_i; that sample is accepted into FILL.
REQ-023 flush_i SHALL clear the window, stable_o and the timeout counter and enter FILL; timeout_o and distance_o SHALL hold.
REQ-024 flush_i and valid_i in the same cycle: flush SHALL win and the sample SHALL be dropped, with no valid_o.
REQ-025 valid_i on consecutive cycles SHALL all be accepted; no back-pressure exists.

Reset
REQ-026 While rst_n = 0: valid_o = 0, distance_o = 0, stable_o = 0, timeout_o = 0, sum = 0, wr_ptr = 0, count = 0, rejection count = 0, state FILL; buffer contents are don't-care.
REQ-027 Reset asserted mid-operation SHALL abort immediately; no valid_o SHALL follow the deassertion until DEPTH new samples are accepted.

Configuration
REQ-028 With macro DISTANCE_FILTER_OUTLIER_EN defined: in RUN, a sample with |distance_i - distance_o| > OUTLIER_TOL SHALL be rejected, with no write and no valid_o, and SHALL increment a 2-bit reject counter.
REQ-029 With the macro defined: a rejection when the reject counter = 2 (third consecutive) SHALL be accepted instead; any acceptance clears the counter; FILL never rejects.
REQ-030 Without DISTANCE_FILTER_OUTLIER_EN: every sample SHALL be accepted, the reject logic SHALL be absent, and OUTLIER_TOL is unused.

Verification
REQ-031 Fill/mean: samples 100, 104, 108, 112 -> single valid_o after the 4th sample, distance_o = 106, stable_o = 0.
REQ-032 Slide/stable: then 116 -> distance_o = 110, stable_o = 0; then 200 ×8 -> final outputs distance_o = 200 with stable_o = 1.
REQ-033 Timeout (TIMEOUT_CYCLES = 100): no valid_i for 100 cycles -> timeout_o = 1, state FILL; next sample clears timeout_o, and no valid_o appears until 4 samples are accepted.
REQ-034 Flush collision: flush_i and valid_i together with distance_i = 500 -> no valid_o, window empty, next 4 samples of 300 -> distance_o = 300.
REQ-035 Outlier (macro on): window 100 ×4, then 300, 300 -> no valid_o; third 300 -> valid_o, distance_o = 150; macro off -> first 300 gives distance_o = 150.
REQ-036 Reset mid-RUN: rst_n low for 1 cycle -> all outputs 0 asynchronously; 3 samples -> no valid_o; 4th -> valid_o.
